// File: rtl/wavetable_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : wavetable_pkg                                                 |
// | Description: Shared types, constants and helpers for the wavetable fetch   |
// |              front end (states, slot tags, read-count constants).          |
// | Config     : WAVETABLE_FETCH_TABLE_INTERP_EN selects four reads per fetch  |
// |              (two tables); undefined selects two reads (one table).        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package wavetable_pkg;

   localparam int c_ADDR_W = 10;
   localparam int c_TBL_W  = 4;

   typedef logic [15:0] sample_t;
   typedef logic [15:0] frac_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_e;

   // Output register selected by a returning read.
   // S<n>I = slot n interp sample, S<n>A = slot n antiInterp sample.
   typedef enum logic [1:0] {
      S0I = 2'd0,
      S0A = 2'd1,
      S1I = 2'd2,
      S1A = 2'd3
   } slot_e;

`ifdef WAVETABLE_FETCH_TABLE_INTERP_EN
   localparam int    c_NREADS    = 4;
   localparam slot_e c_LAST_SLOT = S0A;
`else
   localparam int    c_NREADS    = 2;
   localparam slot_e c_LAST_SLOT = S1A;
`endif

   localparam logic [1:0] c_LAST_CNT = 2'(c_NREADS - 1);

   // Read n: bit0 selects sample i / i+1, bit1 selects table t / t+1.
   // Table t lands in slot 1, table t+1 in slot 0.
   function automatic slot_e slot_of_read(input logic [1:0] cnt);
      return slot_e'({~cnt[1], cnt[0]});
   endfunction

endpackage
`default_nettype wire

// File: rtl/wavetable_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : wavetable_fetch_if                                            |
// | Description: Wavetable RAM read bus.                                       |
// |   ram_rd    : read strobe (master -> RAM)                                  |
// |   ram_addr  : {table, sample} read address (master -> RAM)                 |
// |   ram_rdata : read data, valid RAM_LAT cycles after ram_rd (RAM -> master) |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface wavetable_fetch_if #(
   parameter int ADDR_W = 10,
   parameter int TBL_W  = 4
);
   logic                      ram_rd;
   logic [TBL_W+ADDR_W-1:0]   ram_addr;
   logic [15:0]               ram_rdata;

   modport master (output ram_rd, output ram_addr, input  ram_rdata);
   modport slave  (input  ram_rd, input  ram_addr, output ram_rdata);
endinterface
`default_nettype wire

// File: rtl/wavetable_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : wavetable_tag_pipe                                            |
// | Description: DEPTH-deep shift register of {valid, slot tag} that follows   |
// |              each RAM read so returning data can be steered to its slot.   |
// | Ports      : clk, rst (async, active-high, clears all stages)              |
// |              in_vld/in_slot   : tag entering with the read strobe          |
// |              out_vld/out_slot : tag aligned with the returning data        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module wavetable_tag_pipe
   import wavetable_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic  clk,
   input  logic  rst,
   input  logic  in_vld,
   input  slot_e in_slot,
   output logic  out_vld,
   output slot_e out_slot
);

   logic  r_vld  [DEPTH];
   slot_e r_slot [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_vld[k]  <= 1'b0;
            r_slot[k] <= S0I;
         end
      end else begin
         r_vld[0]  <= in_vld;
         r_slot[0] <= in_slot;
         for (int k = 1; k < DEPTH; k++) begin
            r_vld[k]  <= r_vld[k-1];
            r_slot[k] <= r_slot[k-1];
         end
      end
   end

   assign out_vld  = r_vld[DEPTH-1];
   assign out_slot = r_slot[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/wavetable_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : wavetable_fetch                                               |
// | Description: Read front end for the bilinear wavetable interpolator.       |
// |              Latches phase/table position on start, issues the RAM reads  |
// |              for one output sample, collects the data and presents it,    |
// |              aligned and held, with a one-cycle out_valid pulse.          |
// | Ports      : clk, rst (async, active-high)                                 |
// |              start, phase[31:0], table_pos[TBL_W+15:0] : fetch request    |
// |              busy                                       : fetch running   |
// |              ram (wavetable_fetch_if.master)            : RAM read bus    |
// |              interp_samples[2], antiInterp_samples[2]   : sample outputs  |
// |              sample_interp, table_interp, out_valid     : fractions/pulse |
// | Config     : WAVETABLE_FETCH_TABLE_INTERP_EN - four reads over tables t   |
// |              and t+1; undefined - two reads of table t, both slots equal, |
// |              table_interp forced to 16'hFFFF.                              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module wavetable_fetch
   import wavetable_pkg::*;
#(
   parameter int ADDR_W  = c_ADDR_W,
   parameter int TBL_W   = c_TBL_W,
   parameter int RAM_LAT = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       phase,
   input  logic [TBL_W+15:0] table_pos,
   output logic              busy,
   output sample_t           interp_samples     [2],
   output sample_t           antiInterp_samples [2],
   output frac_t             sample_interp,
   output frac_t             table_interp,
   output logic              out_valid,
   wavetable_fetch_if.master ram
);

   fetch_state_e      r_state, w_next_state;
   logic [ADDR_W-1:0] r_idx;
   logic [TBL_W-1:0]  r_tbl;
   logic [TBL_W-1:0]  w_tbl_next;
   frac_t             r_sfrac, r_tfrac;
   logic [1:0]        r_cnt;
   logic              w_tag_vld;
   slot_e             w_tag_slot;
   logic              w_load;
   sample_t           r_stage     [4];
   sample_t           w_stage_nxt [4];
   sample_t           r_out       [4];
   frac_t             r_sfrac_out, r_tfrac_out;

   // Bits of phase below the sample fraction carry no meaning here.
   generate
      if (ADDR_W < 16) begin : g_phase_tail
         logic w_unused_tail;
         assign w_unused_tail = ^phase[15-ADDR_W:0];
      end
   endgenerate

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = ISSUE;
         ISSUE:   if (r_cnt == c_LAST_CNT) w_next_state = DRAIN;
         DRAIN:   if (w_tag_vld && (w_tag_slot == c_LAST_SLOT)) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DONE);

   // ---------------- request latch / read counter ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_tbl   <= '0;
         r_sfrac <= '0;
         r_tfrac <= '0;
         r_cnt   <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_idx   <= phase[31:32-ADDR_W];
         r_sfrac <= phase[31-ADDR_W:16-ADDR_W];
         r_tbl   <= table_pos[TBL_W+15:16];
`ifdef WAVETABLE_FETCH_TABLE_INTERP_EN
         r_tfrac <= table_pos[15:0];
`else
         r_tfrac <= 16'hFFFF;
`endif
         r_cnt   <= '0;
      end else if ((r_state == ISSUE) && (r_cnt != c_LAST_CNT)) begin
         r_cnt   <= r_cnt + 2'd1;
      end
   end

`ifndef WAVETABLE_FETCH_TABLE_INTERP_EN
   logic w_unused_tfrac;
   assign w_unused_tfrac = ^table_pos[15:0];
`endif

   // t+1 saturates on the last table; i+1 wraps naturally in ADDR_W bits.
   // The address is built from held registers, so it keeps its last value
   // outside read cycles.
   assign w_tbl_next   = (r_tbl == {TBL_W{1'b1}}) ? r_tbl : r_tbl + 1'b1;
   assign ram.ram_rd   = (r_state == ISSUE);
   assign ram.ram_addr = {(r_cnt[1] ? w_tbl_next : r_tbl),
                          r_idx + ADDR_W'(r_cnt[0])};

   // ---------------- tag pipe ----------------
   wavetable_tag_pipe #(
      .DEPTH    (RAM_LAT)
   ) u_tag_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (ram.ram_rd),
      .in_slot  (slot_of_read(r_cnt)),
      .out_vld  (w_tag_vld),
      .out_slot (w_tag_slot)
   );

   // ---------------- data collection ----------------
`ifndef WAVETABLE_FETCH_TABLE_INTERP_EN
   slot_e w_pair_slot;
   assign w_pair_slot = slot_e'(w_tag_slot ^ 2'b10);
`endif

   always_comb begin
      w_stage_nxt = r_stage;
      if (w_tag_vld) begin
         w_stage_nxt[w_tag_slot] = ram.ram_rdata;
`ifndef WAVETABLE_FETCH_TABLE_INTERP_EN
         // Single-table build: each word also fills the matching slot-0 entry.
         w_stage_nxt[w_pair_slot] = ram.ram_rdata;
`endif
      end
   end

   // Outputs load on the edge that captures the final word, so they change
   // exactly in the out_valid cycle and hold until the next fetch's DONE.
   assign w_load = (r_state == DRAIN) && (w_next_state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            r_stage[k] <= '0;
            r_out[k]   <= '0;
         end
         r_sfrac_out <= '0;
         r_tfrac_out <= '0;
      end else begin
         r_stage <= w_stage_nxt;
         if (w_load) begin
            r_out       <= w_stage_nxt;
            r_sfrac_out <= r_sfrac;
            r_tfrac_out <= r_tfrac;
         end
      end
   end

   assign interp_samples[0]     = r_out[S0I];
   assign interp_samples[1]     = r_out[S1I];
   assign antiInterp_samples[0] = r_out[S0A];
   assign antiInterp_samples[1] = r_out[S1A];
   assign sample_interp         = r_sfrac_out;
   assign table_interp          = r_tfrac_out;

endmodule
`default_nettype wire
